// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the four-requester round-robin mux arbiter.
//   sel_t : 2-bit requester index, used for ptr, grant and mux select
//   N_REQ : number of requesters sharing the mux
package rr_mux_pkg;

  typedef logic [1:0] sel_t;

  localparam int N_REQ = 4;

endpackage : rr_mux_pkg

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker for four requesters.
// The search starts at ptr and walks upwards mod 4. The first set request
// bit wins.
// Ports:
//   req     in  [3:0]  request vector, bit i = requester i wants service
//   ptr     in  sel_t  highest-priority requester this cycle
//   grant   out sel_t  winning requester index (equals ptr when idle)
//   any_req out        at least one request is set
module rr_pick_4
  import rr_mux_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             grant,
  output logic             any_req
);

  sel_t cand;

  always_comb begin
    grant   = ptr;
    any_req = 1'b0;
    cand    = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // 2-bit wrap of ptr+k gives the rotated search order
      cand = sel_t'(ptr + sel_t'(k));
      if (!any_req && req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule : rr_pick_4

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter that shares one W-bit 4:1 mux among four valid/ready
// requesters. It drives a single registered valid/ready output port.
// Ports:
//   clk        in        clock, all state on rising edge
//   rst_n      in        asynchronous active-low reset
//   in_valid   in  [3:0] bit i = requester i has data
//   d0..d3     in  [W-1:0] requester data
//   in_ready   out [3:0] bit i = requester i's word is taken this cycle
//   out_valid  out       output register holds a word
//   out_data   out [W-1:0] registered selected data
//   out_src    out [1:0] requester index that produced out_data
//   out_ready  in        consumer accepts out_data
module rr_mux_arbiter_4
  import rr_mux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  sel_t       ptr;
  sel_t       grant;
  logic       any_req;
  logic       load_en;
  logic       take;
  logic [W-1:0] sel_data;

  rr_pick_4 u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  // The output register can accept a new word when empty or being drained.
  assign load_en = !out_valid || out_ready;
  assign take    = load_en && any_req;

  always_comb begin
    unique case (grant)
      2'd0:    sel_data = d0;
      2'd1:    sel_data = d1;
      2'd2:    sel_data = d2;
      default: sel_data = d3;
    endcase
  end

  // While in reset, out_valid is 0 and load_en would be 1. Gating with
  // rst_n keeps requesters from seeing a handshake that the register
  // cannot capture.
  always_comb begin
    in_ready = '0;
    if (rst_n && take) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= grant;
      ptr       <= sel_t'(grant + 2'd1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : rr_mux_arbiter_4

// File: tb/tb_rr_mux_arbiter_4.sv
// Scoreboard bench for rr_mux_arbiter_4: accepted words are queued when the
// handshake is predicted and compared when the output register drains.
module tb_rr_mux_arbiter_4;
  import rr_mux_pkg::*;

  localparam int W = 8;

  typedef struct {
    sel_t         src;
    logic [W-1:0] data;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] dv [4];
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  word_t sb [$];
  sel_t  seen [$];
  sel_t  mptr;
  logic [3:0] taken;

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d0        (dv[0]),
    .d1        (dv[1]),
    .d2        (dv[2]),
    .d3        (dv[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_pick(input logic [3:0] req, input sel_t p,
                            output sel_t g, output logic any);
    g = p;
    any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[(int'(p) + k) % 4]) begin
        g = sel_t'((int'(p) + k) % 4);
        any = 1'b1;
      end
    end
  endtask

  // One cycle: check at the falling edge, update the model, return at posedge+1.
  task automatic step();
    sel_t       g;
    logic       any;
    logic       ld;
    logic [3:0] exp_rdy;
    @(negedge clk);
    ld = (sb.size() == 0) || out_ready;
    model_pick(in_valid, mptr, g, any);
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_data", 32'(out_data), 32'(sb[0].data));
      check("out_src", 32'(out_src), 32'(sb[0].src));
      if (out_ready) begin
        seen.push_back(out_src);
        void'(sb.pop_front());
      end
    end
    exp_rdy = (ld && any) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    taken = exp_rdy;
    if (ld && any) begin
      sb.push_back('{src: g, data: dv[g]});
      mptr = sel_t'(g + 2'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input int first, input int n,
                           input logic [7:0] exp0, input logic [7:0] exp1,
                           input logic [7:0] exp2, input logic [7:0] exp3,
                           input logic [7:0] exp4);
    logic [7:0] e [5];
    logic [31:0] got;
    e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3; e[4] = exp4;
    for (int i = 0; i < n; i++) begin
      got = (first + i < seen.size()) ? 32'(seen[first + i]) : 32'hFFFF_FFFF;
      check(tag, got, 32'(e[i]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dv[i] = '0;
    mptr  = '0;
    taken = '0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle after reset
    repeat (5) step();
    check("idle_out_data", 32'(out_data), 32'h0);

    // Lone requester streams every cycle
    dv[2] = 8'h0A;
    in_valid = 4'b0100;
    seen.delete();
    repeat (4) step();
    check_seq("single_src", 0, 3, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0);
    check("single_data", 32'(out_data), 32'h0A);
    in_valid = '0;
    step();
    step();

    // Reset so ptr starts at 0, then all four valid
    rst_n = 1'b0;
    #1 sb.delete();
    mptr = '0;
    #1 rst_n = 1'b1;
    dv[0] = 8'd1; dv[1] = 8'd2; dv[2] = 8'd3; dv[3] = 8'd4;
    in_valid = 4'b1111;
    seen.delete();
    repeat (6) step();
    check_seq("rr_src", 0, 5, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0);
    check("rr_data_last", 32'(out_data), 32'd2);

    // Async reset mid-stream with a pending word under backpressure
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h0);
    sb.delete();
    mptr = '0;
    #1 rst_n = 1'b1;

    // Backpressure: first load from requester 0, then 4 stalled cycles
    out_ready = 1'b1;
    seen.delete();
    step();
    out_ready = 1'b0;
    repeat (4) step();
    check("bp_src", 32'(out_src), 32'h0);
    check("bp_data", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    check_seq("bp_seq", 0, 3, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0);

    // Wrap and skip: grant 2 leaves ptr=3, then requesters 3 and 0 alternate
    in_valid = 4'b0100;
    step();
    in_valid = 4'b1001;
    seen.delete();
    repeat (4) step();
    check_seq("wrap_seq", 1, 3, 8'd3, 8'd0, 8'd3, 8'd0, 8'd0);
    in_valid = '0;
    step();
    step();

    // Random traffic with protocol-respecting requesters
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (taken[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 1) == 1);
          dv[i] = W'($urandom);
        end
      end
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    check("drain_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux_arbiter_4

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
Round-robin arbiter that shares one 4:1 data mux among four valid/ready requesters. The result goes to a single registered output port. The block generates the mux select from the grant, performs the handshakes, and holds the output stable under backpressure. It sits in front of any single-consumer resource that four producers contend for.

Parameters:
W, 4, data width of each requester and of the output (any value >= 1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  4  bit i = requester i has data
d0, d1, d2, d3  input  W each  requester data
in_ready  output  4  bit i = requester i's data is taken this cycle (one-hot or zero)
out_valid  output  1  output register holds a word
out_data  output  W  registered selected data
out_src  output  2  index of the requester that produced out_data
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is combinational and is 0 while rst_n=0.
- State:
  - ptr[1:0] is the highest-priority requester.
  - The output register holds out_valid, out_data and out_src.
- load_en = !out_valid || out_ready.
- Grant (combinational): search in_valid starting at ptr, ascending mod 4. The first set bit wins and gives grant[1:0] and any_req. With no request, any_req=0.
- sel = grant drives the 4:1 select: sel 0→d0, 1→d1, 2→d2, 3→d3. Slices are independent per bit.
- in_ready[i] = load_en && any_req && (grant==i). in_ready is never multi-hot.
- On a clock with load_en && any_req:
  - out_data <= selected data
  - out_src <= grant
  - out_valid <= 1
  - ptr <= grant+1 mod 4 (3 wraps to 0)
- On a clock with out_valid && out_ready && !any_req: out_valid <= 0. out_data and out_src hold their last value.
- Stall (out_valid && !out_ready):
  - in_ready = 0 and ptr is unchanged.
  - out_data and out_src are stable.
  - The grant may change combinationally but has no effect.
- Latency: a word accepted at edge N is visible on out_* after edge N. Full throughput is 1 word/cycle while out_ready=1.
- Simultaneous out accept and new load in the same cycle: the register is overwritten with the new word and out_valid stays 1. There is no bubble.
- Fairness: a requester holding valid waits at most 3 grants to others.
- Idle: with no requests, ptr is unchanged. A lone requester is granted every cycle regardless of ptr.
- Protocol: a requester holds in_valid and data until its in_ready. The bench asserts this; the RTL does not depend on it.
- Reset mid-transfer: any pending out word is dropped immediately (out_valid=0 asynchronously). ptr returns to 0.
- Arithmetic: ptr+1 is 2-bit modular. No other arithmetic.

Decomposition:
- Package rr_mux_pkg:
  - typedef logic [1:0] sel_t
  - localparam int N_REQ = 4
- Sub-module rr_pick_4:
  - Combinational.
  - Inputs: req[3:0], ptr sel_t.
  - Outputs: grant sel_t, any_req.
- The data select is an inline W-bit 4:1 mux driven by grant. The top level holds the output register and ptr.

Test Plan:
- Reset then idle: rst_n low→high, in_valid=0000 for 5 cycles → out_valid=0, in_ready=0000, out_data=0.
- Single requester: in_valid=0100, d2=4'hA, out_ready=1 → in_ready=0100 every cycle; out_data=A, out_src=2 one cycle later; stream continues 1/cycle.
- All four valid, d0..d3=1,2,3,4, out_ready=1 from reset → grants 0,1,2,3,0 on consecutive cycles; out_src sequence 0,1,2,3,0; out_data 1,2,3,4,1.
- Backpressure: all valid, out_ready=0 after the first load (out_src=0, data=1) → in_ready=0000 and out_* stable for 4 cycles. out_ready=1 → next out_src=1, no word lost or duplicated.
- Wrap and skip: ptr=3 after granting 2, in_valid=1001 → grant 3, then 0, then 3.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1, out_ready=0 → out_valid drops to 0 immediately, in_ready=0000. After release, the first grant goes to requester 0 if valid.
